// File: rtl/mul_cell_share_arbiter.sv
// Round-robin share of one 3-partial 16x16 multiplier cell between two requesters; 4 cycles per op
// (accept, ISSUE, COMBINE, RESP). A stalled response holds the FSM in RESP and blocks new grants.
module mul_cell_share_arbiter #(
  parameter int HALF_W     = 16,
  parameter int FIRST_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [2*HALF_W-1:0] req0_a,
  input  logic [2*HALF_W-1:0] req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [2*HALF_W-1:0] req1_a,
  input  logic [2*HALF_W-1:0] req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [2*HALF_W-1:0] rsp0_data,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [2*HALF_W-1:0] rsp1_data,
  output logic [2*HALF_W-1:0] mul_src1,
  output logic [2*HALF_W-1:0] mul_src2,
  output logic                mul_en,
  input  logic [2*HALF_W-1:0] mul_p1,
  input  logic [2*HALF_W-1:0] mul_p2,
  input  logic [2*HALF_W-1:0] mul_p3
);
  localparam int W = 2 * HALF_W;

  typedef enum logic [1:0] {IDLE, ISSUE, COMBINE, RESP} state_t;

  state_t         r_state;
  logic           r_idle;
  logic           r_last;
  logic           r_owner;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_result;
  logic           r_mul_en;
  logic           r_rsp0_valid;
  logic           r_rsp1_valid;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_xfer;
  logic           w_rsp_hs;
  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_comb;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign w_gnt1   = req1_valid & (~req0_valid | ~r_last);
  assign w_gnt0   = req0_valid & ~w_gnt1;
  assign w_xfer   = r_idle & (req0_valid | req1_valid);
  assign w_rsp_hs = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

  // Upper half of p2+p3 and its carry fall off the top of the 2*HALF_W result.
  assign w_sum    = mul_p2 + mul_p3;
  assign w_comb   = mul_p1 + (w_sum << HALF_W);

  assign req0_ready = r_idle & w_gnt0;
  assign req1_ready = r_idle & w_gnt1;
  assign mul_en     = r_mul_en;
  assign mul_src1   = r_mul_en ? r_a : '0;
  assign mul_src2   = r_mul_en ? r_b : '0;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_valid ? r_result : '0;
  assign rsp1_data  = r_rsp1_valid ? r_result : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_idle       <= 1'b0;
      r_last       <= (FIRST_PRIO != 0) ? 1'b0 : 1'b1;
      r_owner      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_mul_en     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idle <= 1'b1;
          if (w_xfer) begin
            r_a      <= w_gnt1 ? req1_a : req0_a;
            r_b      <= w_gnt1 ? req1_b : req0_b;
            r_owner  <= w_gnt1;
            r_last   <= w_gnt1;
            r_idle   <= 1'b0;
            r_mul_en <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_mul_en <= 1'b0;
          r_state  <= COMBINE;
        end
        COMBINE: begin
          r_result     <= w_comb;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_idle       <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
